// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronised RX, mid-bit sampling, valid/read handshake
// with one-cycle done/framing pulses and a sticky overrun flag.
module uart_receiver #(
  parameter int CYCLES_PER_BIT = 16,
  parameter int HALF_BIT       = CYCLES_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       enable,
  input  logic       RX,
  input  logic       data_read,
  output logic [7:0] data_byte,
  output logic       RX_valid,
  output logic       RX_busy,
  output logic       RX_done,
  output logic       framing_err,
  output logic       overrun_err
);

  localparam int CW = $clog2(CYCLES_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bits_q, bits_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          rx_meta_q, rx_s_q;
  logic          complete;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bits_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    complete = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bits_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d           = '0;
          shift_d[bits_q] = rx_s_q;
          if (bits_q == 3'd7) begin
            bits_d  = '0;
            state_d = STOP;
          end else begin
            bits_d = bits_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Disable aborts the frame but leaves the delivered byte untouched
    if (!enable) begin
      state_d  = IDLE;
      cnt_d    = '0;
      bits_d   = '0;
      complete = 1'b0;
      ferr_d   = 1'b0;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    done_d  = complete;
    if (data_read) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (complete) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !data_read) ovr_d = 1'b1;
    end
  end

  assign data_byte   = data_q;
  assign RX_valid    = valid_q;
  assign RX_done     = done_q;
  assign framing_err = ferr_q;
  assign overrun_err = ovr_q;
  assign RX_busy     = (state_q == START) || (state_q == DATA) ||
                       (state_q == STOP);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame table with a byte scoreboard
// plus hand-written glitch, back-to-back, enable-abort and reset sequences.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       RST;
  logic       enable;
  logic       RX;
  logic       data_read;
  logic [7:0] data_byte;
  logic       RX_valid;
  logic       RX_busy;
  logic       RX_done;
  logic       framing_err;
  logic       overrun_err;

  uart_receiver #(.CYCLES_PER_BIT(CPB)) dut (
    .clk        (clk),
    .RST        (RST),
    .enable     (enable),
    .RX         (RX),
    .data_read  (data_read),
    .data_byte  (data_byte),
    .RX_valid   (RX_valid),
    .RX_busy    (RX_busy),
    .RX_done    (RX_done),
    .framing_err(framing_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_ferr = 0;
  int done_cyc[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every RX_done must match the oldest expected byte
  always @(negedge clk) begin
    if (RST) begin
      if (RX_done) begin
        n_done++;
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(data_byte), 32'hxx);
        end else begin
          check("sb_data_byte", 32'(data_byte), 32'(exp_q.pop_front()));
        end
      end
      if (framing_err) n_ferr++;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clk);
    end
    RX = stop;
    repeat (CPB) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (RX_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rd;
    logic [7:0] exp_byte;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_dones;
    int         exp_ferrs;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit ok;
    int d0;
    int f0;

    vecs[0] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1, 0};
    vecs[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1, 0};
    vecs[2] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1, 0};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 0, 1};
    vecs[4] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1, 0};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1, 0};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1, 0};

    RST = 1'b0;
    enable = 1'b1;
    RX = 1'b1;
    data_read = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_byte", 32'(data_byte), 0);
    check("rst_valid", 32'(RX_valid), 0);
    check("rst_busy", 32'(RX_busy), 0);
    check("rst_done", 32'(RX_done), 0);
    check("rst_ferr", 32'(framing_err), 0);
    check("rst_ovr", 32'(overrun_err), 0);
    RST = 1'b1;
    repeat (4) @(negedge clk);

    // Back-to-back frames with a read after each completion
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    d0 = done_cyc.size();
    fork
      begin
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_done(400, ok);
          check("b2b_done_seen", 32'(ok), 1);
          pulse_read();
          check("b2b_valid_clr", 32'(RX_valid), 0);
          check("b2b_ovr", 32'(overrun_err), 0);
        end
      end
    join
    repeat (20) @(negedge clk);
    check("b2b_done_count", 32'(done_cyc.size() - d0), 2);
    if (done_cyc.size() - d0 == 2)
      check("b2b_spacing", 32'(done_cyc[d0+1] - done_cyc[d0]), 160);
    check("b2b_last_byte", 32'(data_byte), 8'h3C);
    check("b2b_ferr", 32'(n_ferr), 0);

    // Start-bit glitch of 5 cycles
    d0 = n_done;
    RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    check("glitch_busy", 32'(RX_busy), 1);
    repeat (20) @(negedge clk);
    check("glitch_idle", 32'(RX_busy), 0);
    check("glitch_done", 32'(n_done - d0), 0);
    check("glitch_ferr", 32'(n_ferr), 0);
    check("glitch_valid", 32'(RX_valid), 0);

    // Table-driven frames: normal, overrun, framing error, recovery
    foreach (vecs[i]) begin
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      d0 = n_done;
      f0 = n_ferr;
      send_frame(vecs[i].data, vecs[i].stop);
      repeat (20) @(negedge clk);
      check($sformatf("v%0d_dones", i), 32'(n_done - d0),
            32'(vecs[i].exp_dones));
      check($sformatf("v%0d_ferrs", i), 32'(n_ferr - f0),
            32'(vecs[i].exp_ferrs));
      check($sformatf("v%0d_byte", i), 32'(data_byte),
            32'(vecs[i].exp_byte));
      check($sformatf("v%0d_valid", i), 32'(RX_valid),
            32'(vecs[i].exp_valid));
      check($sformatf("v%0d_ovr", i), 32'(overrun_err),
            32'(vecs[i].exp_ovr));
      check($sformatf("v%0d_busy", i), 32'(RX_busy), 0);
      if (vecs[i].rd) begin
        pulse_read();
        check($sformatf("v%0d_rd_valid", i), 32'(RX_valid), 0);
        check($sformatf("v%0d_rd_ovr", i), 32'(overrun_err), 0);
      end
    end

    // Disable during bit 3 of 0x99, keep low until the frame is over
    d0 = n_done;
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (CPB * 4 + 8) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("dis_busy", 32'(RX_busy), 0);
      end
    join
    repeat (4) @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("dis_no_done", 32'(n_done - d0), 0);
    check("dis_keep_byte", 32'(data_byte), 8'hFF);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    repeat (20) @(negedge clk);
    check("dis_42_done", 32'(n_done - d0), 1);
    check("dis_42_byte", 32'(data_byte), 8'h42);
    check("dis_42_valid", 32'(RX_valid), 1);

    // Reset mid-DATA: outputs clear at once, then a clean 0xFF frame
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (50) @(negedge clk);
        check("pre_rst_busy", 32'(RX_busy), 1);
        #2 RST = 1'b0;
        #1;
        check("mid_rst_byte", 32'(data_byte), 0);
        check("mid_rst_valid", 32'(RX_valid), 0);
        check("mid_rst_busy", 32'(RX_busy), 0);
        check("mid_rst_ovr", 32'(overrun_err), 0);
      end
    join
    repeat (4) @(negedge clk);
    RST = 1'b1;
    repeat (4) @(negedge clk);
    d0 = n_done;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    check("post_rst_done", 32'(n_done - d0), 1);
    check("post_rst_byte", 32'(data_byte), 8'hFF);
    check("post_rst_ovr", 32'(overrun_err), 0);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive-side companion of the UART transmitter: deserialises the asynchronous RX line into bytes.
- Frame format: 8N1, LSB first, 16 clk per bit, matching the transmitter's bit timing.
- Sits between the external RX pin and the UART data/status registers on the APB side.
- Presents each received byte with a valid/read handshake, and flags framing and overrun errors.

Parameters:
- CYCLES_PER_BIT, 16: clk cycles per bit; must be even and ≥4; must equal transmitter bit period.
- HALF_BIT, CYCLES_PER_BIT/2: cycles from start-edge detection to the start-bit validation sample.

Ports:
- clk  input  1  system clock, all logic on rising edge
- RST  input  1  asynchronous active-low reset
- enable  input  1  block enable; low forces IDLE and aborts any frame
- RX  input  1  serial line, asynchronous to clk, idles high
- data_read  input  1  one-cycle pulse from register interface acknowledging data_byte
- data_byte  output  8  last correctly received byte
- RX_valid  output  1  data_byte holds an unread byte
- RX_busy  output  1  frame reception in progress (START/DATA/STOP)
- RX_done  output  1  one-cycle pulse when a good frame completes
- framing_err  output  1  one-cycle pulse: stop bit sampled low
- overrun_err  output  1  sticky: byte completed while RX_valid=1; cleared by data_read

Behaviour:
- Reset (RST low, async): all outputs 0, data_byte=0, state IDLE, counters 0.
  - 2-flop RX synchroniser resets to 1 (idle line).
- RX is always used through the 2-flop synchroniser (rx_s); raw RX never feeds logic.
- States: IDLE, START, DATA, STOP, BREAK. Single counter Counter (0..CYCLES_PER_BIT-1) and bitsNum (0..7).
- IDLE: Counter=0, bitsNum=0, RX_busy=0. If enable and rx_s==0, go to START.
- START: Counter increments each cycle. At Counter==HALF_BIT-1, sample rx_s:
  - rx_s=0: Counter←0, go to DATA.
  - rx_s=1 (glitch): go to IDLE; no flags raised.
- DATA: at Counter==CYCLES_PER_BIT-1, shift rx_s into shift register bit[bitsNum] (LSB first), then Counter←0.
  - bitsNum 0..6: bitsNum increments.
  - bitsNum==7: go to STOP.
- STOP: at Counter==CYCLES_PER_BIT-1, sample rx_s:
  - rx_s=1: data_byte←shift register, RX_valid←1, RX_done pulses for 1 cycle; go to IDLE.
  - rx_s=0: framing_err pulses for 1 cycle; data_byte and RX_valid unchanged; go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line from re-triggering.
- RX_busy=1 in START, DATA and STOP only.
- Handshake:
  - RX_valid stays 1 until a data_read pulse clears it.
  - data_read while RX_valid=0 is ignored.
  - Good frame completing while RX_valid=1 and no data_read that cycle: data_byte is overwritten, overrun_err←1.
  - Completion in the same cycle as data_read: RX_valid stays 1 with the new byte, no overrun.
  - data_read clears overrun_err in the same cycle.
- enable low in any state: next edge goes to IDLE, Counter/bitsNum cleared, partial byte discarded, no RX_done/framing_err.
  - data_byte, RX_valid and overrun_err are preserved.
- Reset mid-frame: immediate return to the reset values above.
- Latency (CYCLES_PER_BIT=16): RX_done asserts 154±1 clk after the RX falling edge of the start bit, i.e. mid stop bit. A back-to-back next frame is accepted without loss.

Test Plan:
- Send 0xA5, 16 clk/bit, back-to-back with 0x3C, data_read after each RX_done:
  - RX_done pulses twice, 160 clk apart; data_byte=0xA5 then 0x3C.
  - RX_valid clears 1 cycle after each data_read; no error flags.
- RX low pulse of 5 clk from idle -> returns to IDLE after the 8-cycle check; no RX_busy after that, no RX_done, no flags.
- Frame 0x55 with stop bit driven low, then line high:
  - framing_err pulses once; data_byte keeps its previous value.
  - State passes through BREAK; the next valid frame 0x0F is received correctly.
- Two frames 0x11, 0x22 with no data_read -> data_byte=0x22, RX_valid=1, overrun_err=1; a single data_read clears both.
- Deassert enable at bitsNum=3 of frame 0x99, reassert, send 0x42 -> no completion for 0x99; 0x42 received correctly.
- Assert RST low mid-DATA -> all outputs 0 immediately; after release, frame 0xFF is received correctly.
